background_subtract: RTL

Pixel-wise motion mask stage placed directly downstream of the two grayscale converters in the motion-detect pipeline. It pops one 8-bit gray pixel from the base (background) FIFO and one from the pedestrian (current) FIFO in lockstep, computes their absolute difference, and thresholds it. It then pushes a binary mask pixel (0xFF motion, 0x00 static) into a single output FIFO. It also counts pixels per frame, flags end-of-frame, and reports the motion-pixel count of the last completed frame.

---
 rtl/motion_pkg.sv | 21 ++
 rtl/frame_counter.sv | 54 +++++
 rtl/background_subtract.sv | 82 ++++++++
 3 files changed

// File: rtl/motion_pkg.sv
// Shared pixel types and helpers for the motion-detect pipeline stages.
package motion_pkg;

  localparam int unsigned PIXEL_W = 8;

  typedef logic [PIXEL_W-1:0] gray_t;

  localparam gray_t MASK_ON  = 8'hFF;
  localparam gray_t MASK_OFF = 8'h00;

  // Nine-bit subtract keeps the sign, so |a - b| never wraps.
  function automatic gray_t abs_diff8(input gray_t a, input gray_t b);
    logic [PIXEL_W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    if (diff[PIXEL_W]) begin
      diff = -diff;
    end
    return diff[PIXEL_W-1:0];
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Counts mask pixels written per frame, pulses at the last one and reports motion pixels.
module frame_counter #(
  parameter int unsigned PIXELS = 768 * 576,
  parameter int unsigned CNT_W  = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             is_motion,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_motion
);

  localparam logic [CNT_W-1:0] LastPix = CNT_W'(PIXELS - 1);

  logic [CNT_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [CNT_W-1:0] frame_motion_q, frame_motion_d;
  logic [CNT_W-1:0] motion_inc;

  always_comb begin
    motion_inc     = {{(CNT_W - 1){1'b0}}, is_motion};
    pix_d          = pix_q;
    mcnt_d         = mcnt_q;
    frame_motion_d = frame_motion_q;
    frame_done     = wr_en && (pix_q == LastPix);
    if (wr_en) begin
      if (frame_done) begin
        // The closing pixel itself still counts toward this frame.
        pix_d          = '0;
        mcnt_d         = '0;
        frame_motion_d = mcnt_q + motion_inc;
      end else begin
        pix_d  = pix_q + 1'b1;
        mcnt_d = mcnt_q + motion_inc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pix_q          <= '0;
      mcnt_q         <= '0;
      frame_motion_q <= '0;
    end else begin
      pix_q          <= pix_d;
      mcnt_q         <= mcnt_d;
      frame_motion_q <= frame_motion_d;
    end
  end

  assign frame_motion = frame_motion_q;

endmodule

// File: rtl/background_subtract.sv
// Pops background and current gray pixels in lockstep, thresholds |diff| into a binary mask.
module background_subtract
  import motion_pkg::*;
#(
  parameter int unsigned WIDTH     = 768,
  parameter int unsigned HEIGHT    = 576,
  parameter gray_t       THRESHOLD = 8'd50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  base_dout,
  input  logic        base_empty,
  output logic        base_rd_en,
  input  logic [7:0]  ped_dout,
  input  logic        ped_empty,
  output logic        ped_rd_en,
  output logic [7:0]  out_din,
  input  logic        out_full,
  output logic        out_wr_en,
  output logic        frame_done,
  output logic [19:0] frame_motion
);

  logic  v1_q, v1_d;
  logic  v2_q, v2_d;
  gray_t d1_q, d1_d;
  gray_t m2_q, m2_d;
  logic  adv;
  logic  pop;

  always_comb begin
    adv  = !v2_q || !out_full;
    pop  = !base_empty && !ped_empty && (!v1_q || adv);
    v1_d = v1_q;
    d1_d = d1_q;
    v2_d = v2_q;
    m2_d = m2_q;
    if (pop) begin
      d1_d = abs_diff8(base_dout, ped_dout);
      v1_d = 1'b1;
    end else if (adv) begin
      v1_d = 1'b0;
    end
    if (adv) begin
      v2_d = v1_q;
      m2_d = (d1_q > THRESHOLD) ? MASK_ON : MASK_OFF;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      d1_q <= '0;
      m2_q <= MASK_OFF;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      d1_q <= d1_d;
      m2_q <= m2_d;
    end
  end

  // Pops are masked while reset is held so upstream FIFOs never lose data to a dropped pipeline.
  assign base_rd_en = pop && reset;
  assign ped_rd_en  = pop && reset;
  assign out_din    = m2_q;
  assign out_wr_en  = v2_q && !out_full;

  frame_counter #(
    .PIXELS(WIDTH * HEIGHT),
    .CNT_W (20)
  ) u_frame_counter (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (out_wr_en),
    .is_motion   (m2_q == MASK_ON),
    .frame_done  (frame_done),
    .frame_motion(frame_motion)
  );

endmodule
